// File: rtl/axi_apb_pkg.sv
// ----------------------------------------------------------------------------
// axi_apb_pkg
//  Shared definitions for the APB/AXI bridge family: AXI response and burst
//  encodings plus the state type of the APB->AXI bridge FSM.
//  No ports (package).
// ----------------------------------------------------------------------------
package axi_apb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_R = 3'd4,
    ST_DONE = 3'd5
  } apb2axi_state_e;

  // Error-class responses (SLVERR/DECERR) share bit 1.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/apb2axi_bridge.sv
// ----------------------------------------------------------------------------
// apb2axi_bridge
//  APB completer -> AXI4 single-beat manager. Every APB transfer is turned
//  into exactly one AXI4 write (AW+W then B) or read (AR then R); the APB
//  access phase is held with PREADY low until the AXI side responds. Only one
//  transaction is ever in flight and nothing is buffered.
//
//  Optional feature: define APB2AXI_PSTRB_EN to add the PSTRB port (APB4
//  byte strobes forwarded to WSTRB_o). Without it WSTRB_o is all ones.
//
//  Ports
//   ACLK, ARESET             clock (rising edge), async active-high reset
//   PSEL/PENABLE/PWRITE      APB control
//   PADDR, PWDATA, [PSTRB]   APB request payload
//   PRDATA, PREADY, PSLVERR  APB completion (PRDATA registered)
//   AW*_o / AWREADY_i        AXI write address channel
//   W*_o  / WREADY_i         AXI write data channel
//   B*_i  / BREADY_o         AXI write response channel
//   AR*_o / ARREADY_i        AXI read address channel
//   R*_i  / RREADY_o         AXI read data channel
// ----------------------------------------------------------------------------
module apb2axi_bridge
  import axi_apb_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH     = 32,
  parameter int          AXI4_ADDRESS_WIDTH = 32,
  parameter int          AXI4_DATA_WIDTH    = 32,
  parameter int          AXI4_ID_WIDTH      = 16,
  parameter int          AXI_ID             = 0,
  parameter logic [2:0]  AXI_PROT           = 3'b000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,

  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0]       PADDR,
  input  logic [AXI4_DATA_WIDTH-1:0]      PWDATA,
`ifdef APB2AXI_PSTRB_EN
  input  logic [AXI4_DATA_WIDTH/8-1:0]    PSTRB,
`endif
  output logic [AXI4_DATA_WIDTH-1:0]      PRDATA,
  output logic                            PREADY,
  output logic                            PSLVERR,

  output logic [AXI4_ID_WIDTH-1:0]        AWID_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0]   AWADDR_o,
  output logic [7:0]                      AWLEN_o,
  output logic [2:0]                      AWSIZE_o,
  output logic [1:0]                      AWBURST_o,
  output logic [2:0]                      AWPROT_o,
  output logic                            AWVALID_o,
  input  logic                            AWREADY_i,

  output logic [AXI4_DATA_WIDTH-1:0]      WDATA_o,
  output logic [AXI4_DATA_WIDTH/8-1:0]    WSTRB_o,
  output logic                            WLAST_o,
  output logic                            WVALID_o,
  input  logic                            WREADY_i,

  input  logic [AXI4_ID_WIDTH-1:0]        BID_i,
  input  logic [1:0]                      BRESP_i,
  input  logic                            BVALID_i,
  output logic                            BREADY_o,

  output logic [AXI4_ID_WIDTH-1:0]        ARID_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0]   ARADDR_o,
  output logic [7:0]                      ARLEN_o,
  output logic [2:0]                      ARSIZE_o,
  output logic [1:0]                      ARBURST_o,
  output logic [2:0]                      ARPROT_o,
  output logic                            ARVALID_o,
  input  logic                            ARREADY_i,

  input  logic [AXI4_ID_WIDTH-1:0]        RID_i,
  input  logic [AXI4_DATA_WIDTH-1:0]      RDATA_i,
  input  logic [1:0]                      RRESP_i,
  input  logic                            RLAST_i,
  input  logic                            RVALID_i,
  output logic                            RREADY_o
);

  localparam logic [2:0] AXSIZE = 3'($clog2(AXI4_DATA_WIDTH / 8));

  apb2axi_state_e                  state, state_n;
  logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q;
  logic [AXI4_DATA_WIDTH-1:0]      wdata_q;
  logic [AXI4_DATA_WIDTH-1:0]      rdata_q;
  logic                            aw_done, w_done;
  logic                            err_q;
  logic                            aw_fire, w_fire;
  logic                            apb_setup;
`ifdef APB2AXI_PSTRB_EN
  logic [AXI4_DATA_WIDTH/8-1:0]    strb_q;
`endif

  // IDs, last-beat and the odd response bit are deliberately not checked.
  logic unused_inputs;
  assign unused_inputs = ^{BID_i, RID_i, RLAST_i, BRESP_i[0], RRESP_i[0]};

  assign apb_setup = PSEL && !PENABLE;

  // Valids/readies decode straight from registered state, so they are glitch
  // free and drop in the same cycle ARESET rises.
  assign AWVALID_o = (state == ST_WR) && !aw_done;
  assign WVALID_o  = (state == ST_WR) && !w_done;
  assign BREADY_o  = (state == ST_WR_B);
  assign ARVALID_o = (state == ST_RD_A);
  assign RREADY_o  = (state == ST_RD_R);
  assign PREADY    = (state == ST_DONE);
  assign PSLVERR   = (state == ST_DONE) && err_q;
  assign PRDATA    = rdata_q;

  assign aw_fire = AWVALID_o && AWREADY_i;
  assign w_fire  = WVALID_o  && WREADY_i;

  assign AWID_o    = AXI4_ID_WIDTH'(AXI_ID);
  assign AWADDR_o  = addr_q;
  assign AWLEN_o   = 8'd0;
  assign AWSIZE_o  = AXSIZE;
  assign AWBURST_o = BURST_INCR;
  assign AWPROT_o  = AXI_PROT;

  assign WDATA_o   = wdata_q;
  assign WLAST_o   = 1'b1;
`ifdef APB2AXI_PSTRB_EN
  assign WSTRB_o   = strb_q;
`else
  assign WSTRB_o   = '1;
`endif

  assign ARID_o    = AXI4_ID_WIDTH'(AXI_ID);
  assign ARADDR_o  = addr_q;
  assign ARLEN_o   = 8'd0;
  assign ARSIZE_o  = AXSIZE;
  assign ARBURST_o = BURST_INCR;
  assign ARPROT_o  = AXI_PROT;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (apb_setup) state_n = PWRITE ? ST_WR : ST_RD_A;
      // AW and W complete independently; leave once both have been seen,
      // counting a handshake happening this very cycle.
      ST_WR:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = ST_WR_B;
      ST_WR_B: if (BVALID_i)  state_n = ST_DONE;
      ST_RD_A: if (ARREADY_i) state_n = ST_RD_R;
      ST_RD_R: if (RVALID_i)  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
`ifdef APB2AXI_PSTRB_EN
      strb_q  <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (apb_setup) begin
            addr_q  <= AXI4_ADDRESS_WIDTH'(PADDR);
            wdata_q <= PWDATA;
`ifdef APB2AXI_PSTRB_EN
            strb_q  <= PSTRB;
`endif
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_WR: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        ST_WR_B: begin
          if (BVALID_i) err_q <= resp_is_err(BRESP_i);
        end
        ST_RD_R: begin
          if (RVALID_i) begin
            rdata_q <= RDATA_i;
            err_q   <= resp_is_err(RRESP_i);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb2axi_bridge.sv
module tb_apb2axi_bridge;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [15:0] AWID_o, BID_i, ARID_o, RID_i;
  logic [31:0] AWADDR_o, ARADDR_o, WDATA_o, RDATA_i;
  logic [7:0]  AWLEN_o, ARLEN_o;
  logic [2:0]  AWSIZE_o, ARSIZE_o, AWPROT_o, ARPROT_o;
  logic [1:0]  AWBURST_o, ARBURST_o, BRESP_i, RRESP_i;
  logic [3:0]  WSTRB_o;
  logic        AWVALID_o, AWREADY_i, WLAST_o, WVALID_o, WREADY_i;
  logic        BVALID_i, BREADY_o, ARVALID_o, ARREADY_i;
  logic        RLAST_i, RVALID_i, RREADY_o;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  apb2axi_bridge dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .AWID_o(AWID_o), .AWADDR_o(AWADDR_o), .AWLEN_o(AWLEN_o), .AWSIZE_o(AWSIZE_o),
    .AWBURST_o(AWBURST_o), .AWPROT_o(AWPROT_o), .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
    .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WLAST_o(WLAST_o), .WVALID_o(WVALID_o), .WREADY_i(WREADY_i),
    .BID_i(BID_i), .BRESP_i(BRESP_i), .BVALID_i(BVALID_i), .BREADY_o(BREADY_o),
    .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
    .ARBURST_o(ARBURST_o), .ARPROT_o(ARPROT_o), .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
    .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i), .RVALID_i(RVALID_i),
    .RREADY_o(RREADY_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
  endtask

  task automatic apb_idle();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    AWREADY_i = 0; WREADY_i = 0; BID_i = '0; BRESP_i = 2'b00; BVALID_i = 0;
    ARREADY_i = 0; RID_i = '0; RDATA_i = '0; RRESP_i = 2'b00; RLAST_i = 1; RVALID_i = 0;
    step(); step();
    chk("rst_pready",  PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata",  PRDATA, 0);
    chk("rst_valids",  {AWVALID_o, WVALID_o, ARVALID_o, BREADY_o, RREADY_o}, 0);
    chk("rst_awaddr",  AWADDR_o, 0);
    ARESET = 1'b0;
    step();

    // ---- write 0xDEADBEEF @0x100, all ready immediately
    setup(1, 32'h100, 32'hDEADBEEF);
    AWREADY_i = 1; WREADY_i = 1; BVALID_i = 1; BRESP_i = 2'b00;
    step();                                      // T1
    PENABLE = 1;
    chk("w1_t1_valids", {AWVALID_o, WVALID_o}, 2'b11);
    chk("w1_awaddr", AWADDR_o, 32'h100);
    chk("w1_wdata",  WDATA_o, 32'hDEADBEEF);
    chk("w1_wstrb",  WSTRB_o, 4'hF);
    chk("w1_consts", {AWLEN_o, AWSIZE_o, AWBURST_o, WLAST_o, AWID_o, AWPROT_o},
        {8'd0, 3'd2, 2'b01, 1'b1, 16'd0, 3'b000});
    chk("w1_t1_pready", PREADY, 0);
    step();                                      // T2
    chk("w1_t2_bready", {AWVALID_o, WVALID_o, BREADY_o, PREADY}, 4'b0010);
    step();                                      // T3
    chk("w1_t3_pready", {PREADY, PSLVERR}, 2'b10);
    apb_idle(); BVALID_i = 0;
    step();
    chk("w1_t4_pready", PREADY, 0);

    // ---- write with WREADY three cycles after AWREADY
    setup(1, 32'h180, 32'h0000_5A5A);
    AWREADY_i = 1; WREADY_i = 0;
    step();                                      // T1
    PENABLE = 1;
    chk("w2_t1_valids", {AWVALID_o, WVALID_o}, 2'b11);
    step();                                      // T2
    chk("w2_t2_valids", {AWVALID_o, WVALID_o, PREADY}, 3'b010);
    chk("w2_t2_wdata", WDATA_o, 32'h0000_5A5A);
    step();                                      // T3
    chk("w2_t3_valids", {AWVALID_o, WVALID_o, PREADY}, 3'b010);
    step();                                      // T4
    chk("w2_t4_valids", {AWVALID_o, WVALID_o, PREADY}, 3'b010);
    WREADY_i = 1;
    step();                                      // T5
    chk("w2_t5_bready", {AWVALID_o, WVALID_o, BREADY_o, PREADY}, 4'b0010);
    BVALID_i = 1;
    step();                                      // T6
    chk("w2_t6_pready", {PREADY, PSLVERR, BREADY_o}, 3'b100);
    apb_idle(); BVALID_i = 0;
    step();
    chk("w2_t7_pready", PREADY, 0);

    // ---- read @0x204, RVALID 5 cycles late
    setup(0, 32'h204, 32'h0);
    ARREADY_i = 1; RVALID_i = 0; RDATA_i = 32'h12345678; RRESP_i = 2'b00;
    step();                                      // T1
    PENABLE = 1;
    chk("r1_arvalid", ARVALID_o, 1);
    chk("r1_araddr",  ARADDR_o, 32'h204);
    chk("r1_consts", {ARLEN_o, ARSIZE_o, ARBURST_o, ARID_o, ARPROT_o},
        {8'd0, 3'd2, 2'b01, 16'd0, 3'b000});
    step();                                      // T2
    chk("r1_rready", {ARVALID_o, RREADY_o}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("r1_wait_pready", PREADY, 0);
      chk("r1_wait_prdata", PRDATA, 0);
      if (i == 4) RVALID_i = 1;
      step();
    end
    chk("r1_done", {PREADY, PSLVERR}, 2'b10);
    chk("r1_prdata", PRDATA, 32'h12345678);
    apb_idle(); RVALID_i = 0;
    step();
    chk("r1_after_pready", PREADY, 0);

    // ---- read with DECERR, then an OKAY write
    setup(0, 32'h208, 32'h0);
    RDATA_i = 32'hCAFEF00D; RRESP_i = 2'b11; RVALID_i = 1;
    step(); PENABLE = 1;
    step();
    step();
    chk("r2_decerr", {PREADY, PSLVERR}, 2'b11);
    chk("r2_prdata", PRDATA, 32'hCAFEF00D);
    apb_idle(); RVALID_i = 0; RRESP_i = 2'b00;
    step();
    chk("r2_after", {PREADY, PSLVERR}, 2'b00);
    setup(1, 32'h20C, 32'h0BAD_CAFE);
    AWREADY_i = 1; WREADY_i = 1; BVALID_i = 1; BRESP_i = 2'b00;
    step(); PENABLE = 1;
    step();
    step();
    chk("w3_okay", {PREADY, PSLVERR}, 2'b10);
    chk("w3_prdata_kept", PRDATA, 32'hCAFEF00D);
    apb_idle(); BVALID_i = 0;
    step();

    // ---- back-to-back write then read, slave holds off B
    setup(1, 32'h300, 32'h11223344);
    step(); PENABLE = 1;                         // T1
    step();                                      // T2 in WR_B
    chk("b2b_t2", {BREADY_o, ARVALID_o, PREADY}, 3'b100);
    step();                                      // T3
    chk("b2b_t3", {BREADY_o, ARVALID_o, PREADY}, 3'b100);
    BVALID_i = 1; BRESP_i = 2'b10;
    step();                                      // T4
    chk("b2b_w_done", {PREADY, PSLVERR, ARVALID_o}, 3'b110);
    BVALID_i = 0; BRESP_i = 2'b00;
    step();                                      // T5 idle, new setup now
    chk("b2b_t5_idle", {PREADY, ARVALID_o}, 2'b00);
    setup(0, 32'h304, 32'h0);
    RDATA_i = 32'hA5A5A5A5; RVALID_i = 1; ARREADY_i = 1;
    step(); PENABLE = 1;                         // T6
    chk("b2b_ar", {ARVALID_o, PREADY}, 2'b10);
    chk("b2b_araddr", ARADDR_o, 32'h304);
    step();                                      // T7
    chk("b2b_rready", {RREADY_o, PREADY}, 2'b10);
    step();                                      // T8
    chk("b2b_r_done", {PREADY, PSLVERR}, 2'b10);
    chk("b2b_prdata", PRDATA, 32'hA5A5A5A5);
    apb_idle(); RVALID_i = 0;
    step();

    // ---- ARESET pulse while ARVALID is high
    setup(0, 32'h400, 32'h0);
    ARREADY_i = 0;
    step(); PENABLE = 1;
    chk("rst_mid_ar1", ARVALID_o, 1);
    step();
    chk("rst_mid_ar2", ARVALID_o, 1);
    #2 ARESET = 1;
    #1;
    chk("rst_mid_arvalid", ARVALID_o, 0);
    chk("rst_mid_pready", {PREADY, RREADY_o}, 2'b00);
    chk("rst_mid_prdata", PRDATA, 0);
    apb_idle();
    step();
    ARESET = 0;
    step();
    chk("rst_mid_idle", {ARVALID_o, AWVALID_o, PREADY}, 3'b000);
    setup(0, 32'h408, 32'h0);
    ARREADY_i = 1; RVALID_i = 1; RDATA_i = 32'h0BADF00D; RRESP_i = 2'b00;
    step(); PENABLE = 1;
    chk("r4_ar", ARVALID_o, 1);
    chk("r4_araddr", ARADDR_o, 32'h408);
    step();
    chk("r4_rready", RREADY_o, 1);
    step();
    chk("r4_done", {PREADY, PSLVERR}, 2'b10);
    chk("r4_prdata", PRDATA, 32'h0BADF00D);
    apb_idle(); RVALID_i = 0;
    step();
    chk("r4_after", PREADY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
